pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control unit; drives the 6-bit stall vector sampled by pc_reg, if_id, id_ex, ex_mem, mem_wb.
//  Arbitrates stall requests from ID, EX and MEM; converts exception requests into a registered flush pulse plus redirect PC.
//  Tracks stall duration for a stuck-pipeline watchdog. Optional stall-cycle performance counter.
// PARAMETERS
//  MAX_STALL   64   consecutive stalled cycles before stall_timeout_o sets; 1..65535
//  CNT_W       32   width of perf_stall_cnt_o
// PORTS
//  clk                 in   1      system clock, rising edge
//  rst                 in   1      asynchronous, active-low reset
//  stallreq_from_id    in   1      load-use hazard in ID
//  stallreq_from_ex    in   1      multi-cycle op in EX (div, madd/msub)
//  stallreq_from_mem   in   1      memory not ready
//  excp_i              in   1      exception/eret taken this cycle
//  excp_pc_i           in   32     handler/return address for excp_i
//  stall               out  6      [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = Stop
//  flush_o             out  1      one-cycle flush of all pipeline registers
//  new_pc_o            out  32     redirect PC, valid while flush_o = 1
//  stall_timeout_o     out  1      sticky: stall lasted MAX_STALL cycles
//  perf_stall_cnt_o    out  CNT_W  stalled-cycle count (CTRL_PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset (rst = 0, async): state = RUN, flush_o = 0, new_pc_o = 0, stall_timeout_o = 0,
//    stall_run_cnt = 0, perf_stall_cnt_o = 0; stall = 6'b000000 combinationally while in reset.
//  - stall is combinational from requests and state (same-cycle; consumers sample at posedge):
//    FLUSH state or excp_i = 1 -> 6'b000000; else mem -> 6'b011111; else ex -> 6'b001111;
//    else id -> 6'b000111; else 6'b000000. Priority: excp > mem > ex > id.
//  - Vector is always a contiguous run of 1s from bit 0; bit k set implies bits 0..k-1 set.
//  - FSM: RUN (no request), STALL (any request, no excp), FLUSH (one cycle after excp_i).
//    RUN/STALL -> FLUSH when excp_i = 1; RUN <-> STALL per any-request at each posedge;
//    FLUSH -> STALL if a request is present that cycle, else RUN; excp_i while in FLUSH ignored.
//  - Flush: on the posedge with excp_i = 1 in RUN/STALL, register flush_o <= 1, new_pc_o <= excp_pc_i.
//    flush_o is high exactly one cycle (the FLUSH cycle); new_pc_o holds its value after.
//    Back-to-back excp_i: first taken, second ignored; excp_i on the cycle after FLUSH is taken.
//  - Watchdog: stall_run_cnt (16 bit) increments each posedge with stall != 0; cleared on any
//    cycle with stall = 0. When it reaches MAX_STALL, stall_timeout_o <= 1, sticky until reset.
//    Counter saturates at MAX_STALL. Stall is never forcibly released.
//  - Reset mid-stall or mid-flush: all state cleared immediately; stall drops to 0 asynchronously.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined: perf_stall_cnt_o += 1 each posedge with stall != 0; saturates at
//    all-ones; FLUSH cycles not counted.
//  Not defined: perf_stall_cnt_o tied to 0, no counter flops; all other behaviour identical.
// TESTING
//  1 Reset, no requests 10 cycles -> stall = 000000, flush_o = 0, stall_timeout_o = 0.
//  2 id, ex, mem requests held 1 cycle each, then ex+id together -> 000111, 001111, 011111, 001111.
//  3 excp_i = 1, excp_pc_i = 0xBFC00380 during mem stall -> stall = 0 same cycle; next cycle
//    flush_o = 1, new_pc_o = 0xBFC00380; following cycle flush_o = 0.
//  4 excp_i high two cycles in a row (PCs 0x100, 0x200) -> one flush_o pulse, new_pc_o = 0x100.
//  5 MAX_STALL = 4, ex request held 4 cycles -> stall_timeout_o rises after 4th posedge, stays 1
//    after request drops; 3-cycle stall, 1 free cycle, 3-cycle stall -> never sets.
//  6 CTRL_PERF_CNT_EN: 5 stalled + 3 free + 2 stalled cycles -> perf_stall_cnt_o = 7; assert rst
//    mid-stall -> counter and stall are 0 before next clk edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit.
//
// Turns stall requests from ID, EX and MEM into the 6-bit stall vector
// sampled by pc_reg, if_id, id_ex, ex_mem and mem_wb. An exception request
// becomes a registered one-cycle flush pulse together with a redirect PC.
// A watchdog counts consecutive stalled cycles and raises a sticky timeout.
//
// Optional feature: define CTRL_PERF_CNT_EN to build a saturating
// stalled-cycle performance counter. When the macro is undefined,
// perf_stall_cnt_o is tied to zero and no counter flops are built.
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous active-low reset
//   stallreq_from_id  load-use hazard in ID
//   stallreq_from_ex  multi-cycle op in EX
//   stallreq_from_mem memory not ready
//   excp_i            exception/eret taken this cycle
//   excp_pc_i         handler/return address for excp_i
//   stall             [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1 = stop
//   flush_o           one-cycle flush of all pipeline registers
//   new_pc_o          redirect PC, valid while flush_o = 1, held afterwards
//   stall_timeout_o   sticky: stall lasted MAX_STALL consecutive cycles
//   perf_stall_cnt_o  stalled-cycle count (zero unless CTRL_PERF_CNT_EN)

module pipe_ctrl #(
    parameter int unsigned MAX_STALL = 64,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic             excp_i,
    input  logic [31:0]      excp_pc_i,
    output logic [5:0]       stall,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             stall_timeout_o,
    output logic [CNT_W-1:0] perf_stall_cnt_o
);

    typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

    localparam logic [15:0] MaxStall = 16'(MAX_STALL);

    state_e      state_q, state_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic        any_req;
    logic        take_excp;
    logic        stalled;

    assign any_req   = stallreq_from_id | stallreq_from_ex | stallreq_from_mem;
    // An exception arriving during the flush cycle is dropped.
    assign take_excp = excp_i && (state_q != StFlush);

    // Same-cycle stall vector; forced low while reset is asserted so the
    // pipeline registers see no stall even before the first clock edge.
    always_comb begin
        stall = 6'b000000;
        if (!rst || state_q == StFlush || excp_i) begin
            stall = 6'b000000;
        end else if (stallreq_from_mem) begin
            stall = 6'b011111;
        end else if (stallreq_from_ex) begin
            stall = 6'b001111;
        end else if (stallreq_from_id) begin
            stall = 6'b000111;
        end
    end

    assign stalled = |stall;

    always_comb begin
        state_d = StRun;
        if (take_excp) begin
            state_d = StFlush;
        end else if (any_req) begin
            state_d = StStall;
        end
    end

    // Consecutive-stall counter, saturating at the watchdog limit.
    always_comb begin
        run_cnt_d = 16'd0;
        if (stalled) begin
            run_cnt_d = (run_cnt_q == MaxStall) ? run_cnt_q : run_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StRun;
            flush_o         <= 1'b0;
            new_pc_o        <= 32'd0;
            run_cnt_q       <= 16'd0;
            stall_timeout_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_o   <= take_excp;
            run_cnt_q <= run_cnt_d;
            if (take_excp) begin
                new_pc_o <= excp_pc_i;
            end
            if (run_cnt_d == MaxStall) begin
                stall_timeout_o <= 1'b1;
            end
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] perf_q;

    // Flush cycles have stall = 0, so they are never counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (stalled && (perf_q != {CNT_W{1'b1}})) begin
            perf_q <= perf_q + CNT_W'(1);
        end
    end

    assign perf_stall_cnt_o = perf_q;
`else
    assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int unsigned CntW = 32;

    logic            clk;
    logic            rst;
    logic            stallreq_from_id;
    logic            stallreq_from_ex;
    logic            stallreq_from_mem;
    logic            excp_i;
    logic [31:0]     excp_pc_i;
    logic [5:0]      stall;
    logic            flush_o;
    logic [31:0]     new_pc_o;
    logic            stall_timeout_o;
    logic [CntW-1:0] perf_stall_cnt_o;

    int checks;
    int failures;

    pipe_ctrl #(
        .MAX_STALL(4),
        .CNT_W    (CntW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_from_id (stallreq_from_id),
        .stallreq_from_ex (stallreq_from_ex),
        .stallreq_from_mem(stallreq_from_mem),
        .excp_i           (excp_i),
        .excp_pc_i        (excp_pc_i),
        .stall            (stall),
        .flush_o          (flush_o),
        .new_pc_o         (new_pc_o),
        .stall_timeout_o  (stall_timeout_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;      // {mem, ex, id}
        logic        excp;
        logic [31:0] pc;
        logic [5:0]  exp_stall;
        logic        exp_flush;
        logic [31:0] exp_pc;
        logic        exp_to;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] req, input logic excp, input logic [31:0] pc);
        stallreq_from_id  = req[0];
        stallreq_from_ex  = req[1];
        stallreq_from_mem = req[2];
        excp_i            = excp;
        excp_pc_i         = pc;
    endtask

    // Drive inputs at negedge, return just after the following posedge.
    task automatic step(input logic [2:0] req, input logic excp, input logic [31:0] pc);
        @(negedge clk);
        set_in(req, excp, pc);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_in(3'b000, 1'b0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic vec_t mk(input logic [2:0] req, input logic excp, input logic [31:0] pc,
                                input logic [5:0] st, input logic fl, input logic [31:0] npc,
                                input logic to);
        vec_t v;
        v.req = req; v.excp = excp; v.pc = pc;
        v.exp_stall = st; v.exp_flush = fl; v.exp_pc = npc; v.exp_to = to;
        return v;
    endfunction

    logic [31:0] exp_perf;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        set_in(3'b000, 1'b0, 32'd0);

        // Outputs sampled before each posedge, after the row's inputs settle.
        vecs[0]  = mk(3'b001, 0, 32'h0,        6'b000111, 0, 32'h0,        0);
        vecs[1]  = mk(3'b010, 0, 32'h0,        6'b001111, 0, 32'h0,        0);
        vecs[2]  = mk(3'b100, 0, 32'h0,        6'b011111, 0, 32'h0,        0);
        vecs[3]  = mk(3'b000, 0, 32'h0,        6'b000000, 0, 32'h0,        0);
        vecs[4]  = mk(3'b011, 0, 32'h0,        6'b001111, 0, 32'h0,        0);
        vecs[5]  = mk(3'b100, 0, 32'h0,        6'b011111, 0, 32'h0,        0);
        vecs[6]  = mk(3'b100, 1, 32'hBFC00380, 6'b000000, 0, 32'h0,        0);
        vecs[7]  = mk(3'b000, 0, 32'h0,        6'b000000, 1, 32'hBFC00380, 0);
        vecs[8]  = mk(3'b000, 0, 32'h0,        6'b000000, 0, 32'hBFC00380, 0);
        vecs[9]  = mk(3'b000, 1, 32'h100,      6'b000000, 0, 32'hBFC00380, 0);
        vecs[10] = mk(3'b000, 1, 32'h200,      6'b000000, 1, 32'h100,      0);
        vecs[11] = mk(3'b000, 0, 32'h0,        6'b000000, 0, 32'h100,      0);
        vecs[12] = mk(3'b000, 1, 32'h300,      6'b000000, 0, 32'h100,      0);
        vecs[13] = mk(3'b100, 0, 32'h0,        6'b000000, 1, 32'h300,      0);
        vecs[14] = mk(3'b000, 1, 32'h400,      6'b000000, 0, 32'h300,      0);
        vecs[15] = mk(3'b000, 0, 32'h0,        6'b000000, 1, 32'h400,      0);
        vecs[16] = mk(3'b000, 0, 32'h0,        6'b000000, 0, 32'h400,      0);

        // Idle after reset: nothing stalls, flushes or times out.
        #3;
        check("stall_in_reset", {26'd0, stall}, 32'd0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(3'b000, 1'b0, 32'd0);
        end
        check("idle_stall", {26'd0, stall}, 32'd0);
        check("idle_flush", {31'd0, flush_o}, 32'd0);
        check("idle_new_pc", new_pc_o, 32'd0);
        check("idle_timeout", {31'd0, stall_timeout_o}, 32'd0);
        check("idle_perf", perf_stall_cnt_o, 32'd0);

        // Table: priority, exception flush, back-to-back exceptions.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            set_in(vecs[i].req, vecs[i].excp, vecs[i].pc);
            #1;
            check($sformatf("vec%0d_stall", i), {26'd0, stall}, {26'd0, vecs[i].exp_stall});
            check($sformatf("vec%0d_flush", i), {31'd0, flush_o}, {31'd0, vecs[i].exp_flush});
            check($sformatf("vec%0d_new_pc", i), new_pc_o, vecs[i].exp_pc);
            check($sformatf("vec%0d_timeout", i), {31'd0, stall_timeout_o},
                  {31'd0, vecs[i].exp_to});
        end

        // Watchdog: 3 stalled, 1 free, 3 stalled never reaches the limit of 4.
        do_reset();
        for (int i = 0; i < 3; i++) step(3'b010, 1'b0, 32'd0);
        step(3'b000, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(3'b010, 1'b0, 32'd0);
        check("wd_3_1_3_timeout", {31'd0, stall_timeout_o}, 32'd0);
        step(3'b000, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(3'b010, 1'b0, 32'd0);
        check("wd_after_3_timeout", {31'd0, stall_timeout_o}, 32'd0);
        step(3'b010, 1'b0, 32'd0);
        check("wd_after_4_timeout", {31'd0, stall_timeout_o}, 32'd1);
        for (int i = 0; i < 3; i++) step(3'b000, 1'b0, 32'd0);
        check("wd_sticky_timeout", {31'd0, stall_timeout_o}, 32'd1);
        check("wd_sticky_stall", {26'd0, stall}, 32'd0);

        // Perf counter: 5 stalled + 3 free + 2 stalled.
        do_reset();
        check("perf_after_reset", perf_stall_cnt_o, 32'd0);
        check("timeout_after_reset", {31'd0, stall_timeout_o}, 32'd0);
        for (int i = 0; i < 5; i++) step(3'b001, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(3'b000, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) step(3'b100, 1'b0, 32'd0);
`ifdef CTRL_PERF_CNT_EN
        exp_perf = 32'd7;
`else
        exp_perf = 32'd0;
`endif
        check("perf_count", perf_stall_cnt_o, exp_perf);
        check("perf_stall_held", {26'd0, stall}, {26'd0, 6'b011111});

        // Reset asserted mid-stall clears everything before the next edge.
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_stall_stall", {26'd0, stall}, 32'd0);
        check("rst_mid_stall_perf", perf_stall_cnt_o, 32'd0);
        check("rst_mid_stall_timeout", {31'd0, stall_timeout_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset asserted during the flush cycle.
        step(3'b000, 1'b1, 32'h0000ABC0);
        check("pre_rst_flush", {31'd0, flush_o}, 32'd1);
        check("pre_rst_new_pc", new_pc_o, 32'h0000ABC0);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_flush_flush", {31'd0, flush_o}, 32'd0);
        check("rst_mid_flush_new_pc", new_pc_o, 32'd0);
        @(negedge clk);
        set_in(3'b000, 1'b0, 32'd0);
        rst = 1'b1;
        step(3'b000, 1'b0, 32'd0);
        check("post_rst_flush", {31'd0, flush_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
